// File: rtl/reg_file_param.sv
// Parameterised multi-port register file with a per-register busy
// scoreboard, optional same-cycle write forwarding and hard-wired r0.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic sb_ok;

  function automatic logic is_r0(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0_ok = we0 && !is_r0(wa0);
  assign wr1_ok = we1 && !is_r0(wa1);
  assign sb_ok  = sb_set && !is_r0(sb_addr);

  // Port 1 is applied last so it wins an address clash; a new
  // reservation is applied after both writes so it beats the clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_ok) begin
      regs_d[wa0] = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[wa1] = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (sb_ok) begin
      busy_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic              sb_hit;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign ra     = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit0   = (BYPASS != 0) && we0 && (wa0 == ra);
    assign hit1   = (BYPASS != 0) && we1 && (wa1 == ra);
    assign sb_hit = sb_set && (sb_addr == ra);

    always_comb begin
      data = regs_q[ra];
      if (hit0) data = wd0;
      if (hit1) data = wd1;
      if (is_r0(ra)) data = '0;
    end

    always_comb begin
      busy = busy_q[ra];
      if ((hit0 || hit1) && !sb_hit) busy = 1'b0;
      if (is_r0(ra)) busy = 1'b0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_busy[k]                  = busy;
  end

endmodule
